// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with fixed latency.
// Optional DMEM_MISALIGN_CHECK_EN rejects requests whose byte address is not word aligned.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam int         NBYTES   = DATA_WIDTH / 8;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic accept;
  logic access;
  logic mem_wr;
  logic addr_err;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;

  assign accept = req_valid && req_ready;
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_wr = access && we_q && !err_q;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign addr_err = (|req_addr[31:ADDR_WIDTH+2]) || (req_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign addr_err = |req_addr[31:ADDR_WIDTH+2];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          we_d    = req_we;
          idx_d   = req_addr[ADDR_WIDTH+1:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = addr_err;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The read sees the word before this edge; loads never write, so no bypass is needed
          state_d = RESP;
          rerr_d  = err_q;
          rdata_d = (!err_q && !we_q) ? mem[idx_q] : '0;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          rerr_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Storage is deliberately left out of reset; only the commit itself is gated by rst
  always_ff @(posedge clk) begin
    if (mem_wr && !rst) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, ADDR_WIDTH=10).
// Expected values follow DMEM_MISALIGN_CHECK_EN when the bench is built with it.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Presents a request and returns at the falling edge after the acceptance edge
  task automatic issueRequest(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_timeout", 32'(n < 20), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitResponse(output int edges);
    edges = 0;
    while (!resp_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic releaseResponse();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("resp_valid_cleared", 32'(resp_valid), 32'd0);
    checkOutput("ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               output logic [31:0] rdata, output logic err);
    int edges;
    issueRequest(we, addr, wdata, be);
    waitResponse(edges);
    checkOutput({tag, "_latency"}, 32'(edges), 32'(LAT));
    rdata = resp_rdata;
    err   = resp_err;
    releaseResponse();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkOutput("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", 32'(req_ready), 32'd1);

    // Full store then load back
    applyStimulus("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
    checkOutput("st10_err", 32'(er), 32'd0);
    checkOutput("st10_rdata", rd, 32'd0);
    applyStimulus("ld10", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    checkOutput("ld10_rdata", rd, 32'hDEADBEEF);
    checkOutput("ld10_err", 32'(er), 32'd0);

    // Partial and empty byte-enable stores
    applyStimulus("st10p", 1'b1, 32'h10, 32'h000000AA, 4'h1, rd, er);
    applyStimulus("ld10p", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    checkOutput("ld10p_rdata", rd, 32'hDEADBEAA);
    applyStimulus("st10z", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er);
    checkOutput("st10z_err", 32'(er), 32'd0);
    applyStimulus("st10h", 1'b1, 32'h10, 32'h11223344, 4'hC, rd, er);
    applyStimulus("ld10h", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    checkOutput("ld10h_rdata", rd, 32'h1122BEAA);

    // Out-of-range address against word 0, plus the last valid word
    applyStimulus("st0", 1'b1, 32'h0, 32'h55AA55AA, 4'hF, rd, er);
    applyStimulus("ld1000", 1'b0, 32'h1000, 32'h0, 4'h0, rd, er);
    checkOutput("ld1000_err", 32'(er), 32'd1);
    checkOutput("ld1000_rdata", rd, 32'd0);
    applyStimulus("st1000", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er);
    checkOutput("st1000_err", 32'(er), 32'd1);
    applyStimulus("ld0", 1'b0, 32'h0, 32'h0, 4'h0, rd, er);
    checkOutput("ld0_rdata", rd, 32'h55AA55AA);
    applyStimulus("stffc", 1'b1, 32'hFFC, 32'hA5A5F00F, 4'hF, rd, er);
    applyStimulus("ldffc", 1'b0, 32'hFFC, 32'h0, 4'h0, rd, er);
    checkOutput("ldffc_rdata", rd, 32'hA5A5F00F);
    checkOutput("ldffc_err", 32'(er), 32'd0);

    // Backpressure: response held, competing request ignored
    issueRequest(1'b0, 32'h10, 32'h0, 4'h0);
    waitResponse(lat);
    checkOutput("hold_latency", 32'(lat), 32'(LAT));
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    req_be    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(resp_valid), 32'd1);
      checkOutput("hold_rdata", resp_rdata, 32'h1122BEAA);
      checkOutput("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    releaseResponse();
    applyStimulus("ld10after", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    checkOutput("ld10after_rdata", rd, 32'h1122BEAA);

    // Reset during WAIT discards a store
    applyStimulus("st20pre", 1'b1, 32'h20, 32'h0, 4'hF, rd, er);
    issueRequest(1'b1, 32'h20, 32'h12345678, 4'hF);
    rst = 1'b1;
    #1;
    checkOutput("rstwait_ready", 32'(req_ready), 32'd0);
    checkOutput("rstwait_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus("ld20", 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
    checkOutput("ld20_rdata", rd, 32'h0);

    // Reset during RESP keeps the committed store
    issueRequest(1'b1, 32'h24, 32'hCAFEF00D, 4'hF);
    waitResponse(lat);
    checkOutput("st24_latency", 32'(lat), 32'(LAT));
    rst = 1'b1;
    #1;
    checkOutput("rstresp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rstresp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("ld24", 1'b0, 32'h24, 32'h0, 4'h0, rd, er);
    checkOutput("ld24_rdata", rd, 32'hCAFEF00D);

    // Misaligned load
    applyStimulus("ld12", 1'b0, 32'h12, 32'h0, 4'h0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    checkOutput("ld12_err", 32'(er), 32'd1);
    checkOutput("ld12_rdata", rd, 32'd0);
`else
    checkOutput("ld12_err", 32'(er), 32'd0);
    checkOutput("ld12_rdata", rd, 32'h1122BEAA);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width; only 32 supported.
REQ-002 Parameter ADDR_WIDTH, default 10, word-index bits; storage depth 2**ADDR_WIDTH words.
REQ-003 Parameter LATENCY, default 2, request-to-response latency in cycles; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_be  input  4  store byte enables; bit n enables byte n (bits 8n+7:8n).
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  initiator accepts response.
REQ-014 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 resp_err  output  1  request rejected, no access performed.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; one request outstanding at a time.
REQ-017 req_ready SHALL be 1 only in IDLE with rst low; 0 in WAIT and RESP.
REQ-018 Acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1; req_we, req_addr, req_wdata, req_be latched at that edge.
REQ-019 On acceptance: IDLE -> WAIT, latency counter loaded with LATENCY-1.
REQ-020 In WAIT: counter != 0 -> decrement; counter == 0 -> perform access at that edge and go RESP.
REQ-021 resp_valid SHALL first be high in the cycle after the LATENCY-th rising edge following the acceptance edge (LATENCY=1: the cycle after the next edge).
REQ-022 In RESP, resp_valid, resp_rdata, resp_err SHALL stay stable until an edge with resp_ready=1; that edge returns to IDLE and clears resp_valid.
REQ-023 req_valid in WAIT or RESP SHALL be ignored; initiator holds it until accepted.
REQ-024 Word index = req_addr[ADDR_WIDTH+1:2]; any 1 in req_addr[31:ADDR_WIDTH+2] SHALL give resp_err=1, no write, resp_rdata=0.
REQ-025 Store: only enabled bytes written; req_be=0 is a legal no-op store; resp_rdata=0, resp_err=0.
REQ-026 Load: resp_rdata = full stored word at the access edge; resp_err=0.
REQ-027 A store followed by a load to the same word SHALL return the stored data (no stale read).
REQ-028 Storage contents SHALL not be reset; power-up contents undefined.

Reset
REQ-029 rst high SHALL immediately force IDLE, counter 0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-030 req_ready SHALL become 1 in the first cycle with rst low.
REQ-031 Reset during WAIT SHALL discard the request; no store commits. Reset during RESP SHALL drop the response; a committed store remains.

Configuration
REQ-032 Macro DMEM_MISALIGN_CHECK_EN defined: req_addr[1:0] != 0 SHALL give resp_err=1, no access, resp_rdata=0, same latency.
REQ-033 Macro undefined: req_addr[1:0] SHALL be ignored; access targets the containing word, resp_err only from REQ-024.

Verification
REQ-034 LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 0xF accepted at edge E0 -> resp_valid high after E2, resp_err=0; then load 0x10 -> resp_rdata 0xDEADBEEF.
REQ-035 Partial store 0x10 wdata 0x000000AA be 0x1 over 0xDEADBEEF -> load 0x10 returns 0xDEADBEAA.
REQ-036 resp_ready held 0 for 5 cycles in RESP -> resp_valid/resp_rdata stable, req_ready 0, second req_valid ignored; resp_ready=1 -> IDLE next cycle, req_ready=1.
REQ-037 Load addr 0x00001000 (ADDR_WIDTH=10) -> resp_err=1, resp_rdata=0; store there -> resp_err=1, word 0 unchanged.
REQ-038 rst pulsed during WAIT of store 0x20 wdata 0x12345678 -> outputs cleared immediately; later load 0x20 does not return 0x12345678 (preloaded 0).
REQ-039 With DMEM_MISALIGN_CHECK_EN: load 0x12 -> resp_err=1; without: load 0x12 returns word at 0x10, resp_err=0.
